// File: rtl/fir_tap_sequencer_if.sv
// Sample-in / result-out / coefficient-write bundle for fir_tap_sequencer.
// slave = the FIR engine, master = the sample source / result sink side.
interface fir_tap_sequencer_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int TAPS        = 8,
  parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + $clog2(TAPS)
);
  localparam int AW = $clog2(TAPS);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; the offering side holds its payload and valid stable until that edge.
  logic signed [DATA_WIDTH-1:0]  in_data;
  logic                          in_valid;
  logic                          in_ready;
  logic                          coef_wr_en;
  logic [AW-1:0]                 coef_wr_addr;
  logic signed [COEFF_WIDTH-1:0] coef_wr_data;
  logic signed [ACC_WIDTH-1:0]   out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic                          busy;
  logic [1:0]                    state_dbg;

  modport master (
    output in_data, in_valid, coef_wr_en, coef_wr_addr, coef_wr_data, out_ready,
    input  in_ready, out_data, out_valid, busy, state_dbg
  );

  modport slave (
    input  in_data, in_valid, coef_wr_en, coef_wr_addr, coef_wr_data, out_ready,
    output in_ready, out_data, out_valid, busy, state_dbg
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR: one signed MAC walks all TAPS coefficients per accepted sample.
// Optional FIR_TAP_SEQUENCER_FLUSH_EN adds a flush input that clears the sample history.
module fir_tap_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int TAPS        = 8,
  parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + $clog2(TAPS)
) (
  input  logic clk,
  input  logic rst,
`ifdef FIR_TAP_SEQUENCER_FLUSH_EN
  input  logic flush,
`endif
  fir_tap_sequencer_if.slave bus
);
  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_WIDTH + COEFF_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]                 k;
  logic [AW-1:0]                 base;
  logic [AW-1:0]                 wr_ptr;
  logic [AW-1:0]                 wr_ptr_inc;
  logic [AW-1:0]                 tap_idx;
  logic signed [DATA_WIDTH-1:0]  x_mem [TAPS];
  logic signed [COEFF_WIDTH-1:0] c_mem [TAPS];
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [PW-1:0]          prod;
  logic                          accept;
  logic                          last_tap;
  logic                          coef_wr_ok;
  logic                          flush_req;

`ifdef FIR_TAP_SEQUENCER_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign last_tap   = (k == AW'(TAPS - 1));
  assign wr_ptr_inc = (wr_ptr == AW'(TAPS - 1)) ? '0 : wr_ptr + 1'b1;
  assign coef_wr_ok = (state == IDLE) && bus.coef_wr_en &&
                      ({1'b0, bus.coef_wr_addr} < (AW + 1)'(TAPS));

  // Delay-line slot holding the sample k steps older than the one at base.
  always_comb begin
    tap_idx = '0;
    if (base >= k) tap_idx = base - k;
    else           tap_idx = AW'(({1'b0, base} + (AW + 1)'(TAPS)) - {1'b0, k});
  end

  assign prod = PW'(c_mem[k]) * PW'(x_mem[tap_idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid && !flush_req) begin
          accept    = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC:     if (last_tap) state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k      <= '0;
      base   <= '0;
      wr_ptr <= '0;
      acc    <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_mem[i] <= '0;
        c_mem[i] <= '0;
      end
    end else begin
      if (coef_wr_ok) c_mem[bus.coef_wr_addr] <= bus.coef_wr_data;
      if (state == IDLE && flush_req) begin
        wr_ptr <= '0;
        for (int i = 0; i < TAPS; i++) x_mem[i] <= '0;
      end else if (accept) begin
        x_mem[wr_ptr] <= bus.in_data;
        base          <= wr_ptr;
        wr_ptr        <= wr_ptr_inc;
        acc           <= '0;
        k             <= '0;
      end else if (state == MAC) begin
        acc <= acc + ACC_WIDTH'(prod);
        k   <= last_tap ? '0 : k + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE) && !flush_req;
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = acc;
  assign bus.busy      = (state != IDLE);
  assign bus.state_dbg = state;

  // A stalled result must stay put until the sink takes it.
  property p_out_hold;
    @(posedge clk) disable iff (rst)
      (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_data));
  endproperty
  a_out_hold: assert property (p_out_hold);
endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Time-multiplexed FIR engine: one shared signed multiplier and accumulator are sequenced across all TAPS coefficients for each accepted input sample. It owns the sample delay line and coefficient bank, accepts samples on a valid/ready handshake, and returns one full-precision filtered result per sample. It sits between the sample source and the downstream pipeline register stages, replacing a fully parallel tap array where area matters more than throughput.

## Interface
- DATA_WIDTH, 16, signed input sample width
- COEFF_WIDTH, 16, signed coefficient width
- TAPS, 8, number of taps; must be ≥ 2
- ACC_WIDTH, DATA_WIDTH+COEFF_WIDTH+$clog2(TAPS), signed accumulator/output width

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_data  in  DATA_WIDTH  signed sample
- in_valid  in  1  sample offered
- in_ready  out  1  sample accepted on in_valid && in_ready
- coef_wr_en  in  1  coefficient write strobe
- coef_wr_addr  in  $clog2(TAPS)  tap index k
- coef_wr_data  in  COEFF_WIDTH  signed coefficient c[k]
- out_data  out  ACC_WIDTH  signed y[n]
- out_valid  out  1  result available
- out_ready  in  1  result consumed on out_valid && out_ready
- busy  out  1  state != IDLE

## Operation
- States: IDLE, MAC, OUT. in_ready = (state==IDLE); out_valid = (state==OUT); out_data = accumulator register.
- IDLE: on in_valid: write in_data to delay line at wr_ptr, latch base = wr_ptr, wr_ptr <= (wr_ptr+1) mod TAPS, acc <= 0, k <= 0, -> MAC.
- MAC: each cycle acc <= acc + c[k] * x[(base - k) mod TAPS] (k=0 newest sample); k <= k+1; after k = TAPS-1 is accumulated -> OUT.
- OUT: hold out_data/out_valid stable until out_ready; on out_ready -> IDLE.
- Arithmetic: signed full-width product (DATA_WIDTH+COEFF_WIDTH), sign-extended to ACC_WIDTH; no truncation, no overflow possible by construction.
- Coefficient writes honoured only in IDLE with coef_wr_addr < TAPS; otherwise silently dropped. Write and sample accept in same IDLE cycle are both performed; new coefficient applies to that sample.
- Delay line starts all-zero, so the first TAPS-1 outputs see zero history.
- Reset (any time, including mid-MAC or OUT): state IDLE, in_ready 1 after release, out_valid 0, out_data 0, busy 0, acc 0, k 0, wr_ptr 0, all delay-line entries 0, all coefficients 0. In-flight sample discarded.

## Timing
- Accept edge = E0. MAC on edges E1..ETAPS; out_valid high after edge ETAPS (latency TAPS cycles).
- With out_ready held high: OUT lasts one cycle, in_ready high again after edge ETAPS+1; throughput one sample per TAPS+2 cycles.
- in_ready low from E0 through the OUT->IDLE edge; in_valid during that window is ignored (source must hold).
- out_data/out_valid never change while out_valid && !out_ready.

## Configuration
- FIR_TAP_SEQUENCER_FLUSH_EN defined: adds input port flush (1 bit). flush high in IDLE zeroes all delay-line entries and wr_ptr on the next edge; in_ready is low that cycle (flush wins over in_valid). flush outside IDLE is ignored. Coefficients unaffected.
- Undefined: no flush port; history is cleared only by rst.

## Test plan
- TAPS=4, c={1,2,3,4}; samples 1,0,0,0,0 with out_ready=1 -> out_data 1,2,3,4,0; each out_valid exactly 4 cycles after its accept edge.
- TAPS=4, c={-1,-1,-1,-1}, DATA_WIDTH=16; four samples -32768 -> outputs 32768,65536,98304,131072 (no wrap in ACC_WIDTH=34).
- Backpressure: out_ready low 10 cycles in OUT -> out_data/out_valid stable, in_ready low throughout, in_valid held sample accepted one cycle after out_ready handshake.
- Coef write to k=0 during MAC and write with addr ≥ TAPS in IDLE -> both ignored; subsequent result matches old coefficient set.
- Assert rst at MAC cycle 2 -> out_valid 0, busy 0, next sample 5 with c={1,2,3,4} reloaded gives 5 (history cleared).
- With FIR_TAP_SEQUENCER_FLUSH_EN: after samples 1,2,3, flush in IDLE, then impulse 1 -> output equals c[0] only (prior history gone).
